regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
Arbitrates the single register-file write port between two write-back requesters: req0 (ALU/execute result) and req1 (load return / debug write).
- Valid/ready handshake per requester; round-robin or fixed priority.
- Registered output stage drives the register file's write_en/write_add/write_reg directly.
- Filters writes to x0 so the register file is never written at address 0 by this path.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register address width
PRIO_MODE, 0, 0 = round-robin between req0/req1; 1 = fixed priority, req0 always wins

Ports:
clk  input  1  clock, rising edge
clear  input  1  asynchronous active-low reset
hold  input  1  stall; while high no request is accepted
req0_valid  input  1  req0 has a write pending
req0_ready  output  1  req0 accepted this cycle
req0_addr  input  ADDR_W  req0 destination register
req0_data  input  DATA_W  req0 write data
req1_valid  input  1  req1 has a write pending
req1_ready  output  1  req1 accepted this cycle
req1_addr  input  ADDR_W  req1 destination register
req1_data  input  DATA_W  req1 write data
wr_en  output  1  to register file write_en
wr_addr  output  ADDR_W  to register file write_add
wr_data  output  DATA_W  to register file write_reg
grant_last  output  1  requester granted by most recent acceptance (0/1)

Behaviour:
- Reset (clear low, async): wr_en=0, wr_addr=0, wr_data=0, grant_last=1 (req0 favoured first), round-robin pointer follows grant_last.
- Handshake: transfer when valid && ready on the same rising edge. Requester must hold valid, addr and data stable until ready. Ready is combinational from valids, hold and pointer; ready never depends on ready.
- At most one acceptance per cycle. The output stage empties every cycle, so no backpressure exists other than hold and the arbitration loss.
- hold=1: both readies 0; wr_en still reflects the previous cycle's acceptance, so the output drains.
- Arbitration, PRIO_MODE=0:
  - Only one valid: that one is granted.
  - Both valid: grant the requester not equal to grant_last.
  - grant_last updates only on acceptance.
- Arbitration, PRIO_MODE=1: req0 wins whenever valid. grant_last is still updated.
- Latency: acceptance at edge N sets wr_en=1 with wr_addr/wr_data registered during cycle N+1. The register file commits at edge N+1. wr_en is a one-cycle pulse per acceptance; back-to-back acceptances give continuous wr_en.
- x0 filter: a request with addr==0 is accepted (ready=1, grant_last updates) but the next cycle has wr_en=0. wr_addr/wr_data still update to the accepted values.
- No acceptance in cycle: wr_en=0 next cycle; wr_addr/wr_data hold their last values.
- Same-address writes from both requesters are serialized in grant order; the later write wins in the register file.
- Reset mid-operation: any in-flight output write is dropped (wr_en forced 0 immediately). Pending requesters are not acknowledged and must re-present after reset.

Optional Feature:
Macro REGFILE_WB_ARB_BYPASS_EN.
- Defined: adds inputs rd_addr_a, rd_addr_b (ADDR_W) and outputs byp_hit_a, byp_hit_b (1) and byp_data (DATA_W).
  - byp_hit_x = wr_en && (wr_addr == rd_addr_x) && (rd_addr_x != 0), combinational.
  - byp_data = wr_data.
  - Lets the datapath forward a value registered in the output stage but not yet committed to the register file.
- Undefined: these ports do not exist; no compare logic.

Decomposition:
- Package regfile_pkg: ADDR_W/DATA_W constants, the X0 address constant, PRIO_RR/PRIO_FIXED encodings.
- One natural sub-module, rr_arbiter2: two requests plus last-grant pointer in, one-hot grant out.
- The arbiter instantiates rr_arbiter2 and owns the output register and the x0 filter.

Test Plan:
- Reset with clear low mid-stream (wr_en=1 pending) -> wr_en=0, wr_addr=0, wr_data=0 immediately; grant_last=1.
- req0 alone, addr=5, data=0xDEADBEEF -> req0_ready=1 at edge N; cycle N+1 wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; cycle N+2 wr_en=0.
- Both valid, held 4 cycles, PRIO_MODE=0, from reset -> grants req0, req1, req0, req1; wr_en high 4 consecutive cycles with matching addr/data. Same stimulus with PRIO_MODE=1 -> req0 granted every cycle, req1_ready stays 0.
- req1 addr=0, data=0x1234 -> req1_ready=1, next cycle wr_en=0, grant_last=1.
- hold=1 for 3 cycles with both valid -> both readies 0, wr_en 0 after the first cycle. Release hold -> arbitration resumes from the preserved grant_last.
- With REGFILE_WB_ARB_BYPASS_EN: accept addr=7 data=0xA5A5A5A5, rd_addr_a=7, rd_addr_b=0 in cycle N+1 -> byp_hit_a=1, byp_hit_b=0, byp_data=0xA5A5A5A5; cycle N+2 byp_hit_a=0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter: widths, the x0
// address and the arbitration-mode encodings.
package regfile_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    // The hard-wired zero register is never written through this path.
    localparam int unsigned X0_ADDR = 0;

    localparam int unsigned PRIO_RR    = 0;
    localparam int unsigned PRIO_FIXED = 1;

    // Encoding of grant_last / last-grant pointer.
    typedef enum logic {
        GNT_REQ0 = 1'b0,
        GNT_REQ1 = 1'b1
    } gnt_idx_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus: two valid/ready requesters in, one registered register-file
// write port plus the last-grant indicator out.
interface regfile_wb_arbiter_if #(
    parameter int unsigned ADDR_W = regfile_pkg::ADDR_W,
    parameter int unsigned DATA_W = regfile_pkg::DATA_W
);

    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;

    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              grant_last;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output wr_en, wr_addr, wr_data, grant_last
    );

    // Requester / register-file side.
    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  wr_en, wr_addr, wr_data, grant_last
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way arbiter: request pair plus last-grant pointer in, one-hot grant out.
// Round-robin favours the requester that did not win last; fixed mode favours req0.
module rr_arbiter2
    import regfile_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_c_o
);

    if (FIXED_PRIO) begin : g_fixed
        always_comb begin
            gnt_c_o    = 2'b00;
            gnt_c_o[0] = req_i[0];
            gnt_c_o[1] = req_i[1] & ~req_i[0];
        end
    end else begin : g_rr
        always_comb begin
            gnt_c_o = 2'b00;
            unique case (req_i)
                2'b01:   gnt_c_o = 2'b01;
                2'b10:   gnt_c_o = 2'b10;
                // Contention: the side that did not win most recently goes next.
                2'b11:   gnt_c_o = (last_i == GNT_REQ1) ? 2'b01 : 2'b10;
                default: gnt_c_o = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: picks one of two write-back requesters per
// cycle, registers the write and suppresses writes to x0.
// Optional forwarding compare from the output stage: REGFILE_WB_ARB_BYPASS_EN.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W    = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W    = regfile_pkg::ADDR_W,
    parameter int unsigned PRIO_MODE = regfile_pkg::PRIO_RR
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              hold,
    regfile_wb_arbiter_if.slave bus
`ifdef REGFILE_WB_ARB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              byp_hit_a,
    output logic              byp_hit_b,
    output logic [DATA_W-1:0] byp_data
`endif
);

    localparam logic [ADDR_W-1:0] X0 = ADDR_W'(regfile_pkg::X0_ADDR);
    localparam bit FIXED_PRIO = (PRIO_MODE == regfile_pkg::PRIO_FIXED);

    logic [1:0]        req_c;
    logic [1:0]        gnt_c;
    logic              accept_c;

    logic              wr_en_q,      wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;
    logic [DATA_W-1:0] wr_data_q,    wr_data_d;
    logic              grant_last_q, grant_last_d;

    // Hold masks both requests, so nothing is granted while stalled.
    assign req_c = {bus.req1_valid, bus.req0_valid} & {2{~hold}};

    rr_arbiter2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .req_i   (req_c),
        .last_i  (grant_last_q),
        .gnt_c_o (gnt_c)
    );

    assign bus.req0_ready = gnt_c[0];
    assign bus.req1_ready = gnt_c[1];
    assign accept_c       = |gnt_c;

    // Output stage refills every cycle; x0 writes are accepted but not enabled.
    always_comb begin
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        grant_last_d = grant_last_q;
        if (accept_c) begin
            wr_addr_d    = gnt_c[1] ? bus.req1_addr : bus.req0_addr;
            wr_data_d    = gnt_c[1] ? bus.req1_data : bus.req0_data;
            wr_en_d      = (wr_addr_d != X0);
            grant_last_d = gnt_c[1];
        end
    end

    // Reset favours req0 first by pretending req1 won last.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            grant_last_q <= 1'b1;
        end else begin
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            grant_last_q <= grant_last_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.grant_last = grant_last_q;

`ifdef REGFILE_WB_ARB_BYPASS_EN
    // Forward a write sitting in the output stage before the register file has it.
    assign byp_hit_a = wr_en_q && (wr_addr_q == rd_addr_a) && (rd_addr_a != X0);
    assign byp_hit_b = wr_en_q && (wr_addr_q == rd_addr_b) && (rd_addr_b != X0);
    assign byp_data  = wr_data_q;
`endif

endmodule
